// File: rtl/prio_arbiter4_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface prio_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    modport master (output req, input gnt, gnt_id, gnt_valid, preempt);
    modport slave  (input req, output gnt, gnt_id, gnt_valid, preempt);
endinterface

// File: rtl/prio_arbiter4.sv
// Registered 4-requester arbiter with grant lock, hold limit and forced release.
// Define PRIO_ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed 3 > 2 > 1 > 0.
module prio_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    prio_arbiter4_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [3:0]       gnt_q, gnt_nxt;
    logic [1:0]       id_q, id_nxt;
    logic             vld_q;
    logic             pre_q, pre_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       lo;
    logic [1:0]       idx;
    logic [1:0]       win_id;
    logic             win_hit;
    logic             own_req;
    logic             others;
    logic             limit_hit;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    // lo marks the lowest-priority index; it follows the most recent winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lo <= 2'd0;
        else if (state == IDLE && win_hit)
            lo <= win_id;
    end
`else
    assign lo = 2'd0;
`endif

    // Search lo-1, lo-2, lo-3, lo; with lo=0 this is the plain encoder order.
    always_comb begin
        win_id  = 2'd0;
        win_hit = 1'b0;
        idx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = lo - 2'(k);
            if (!win_hit && bus.req[idx]) begin
                win_id  = idx;
                win_hit = 1'b1;
            end
        end
    end

    assign own_req   = bus.req[id_q];
    assign others    = |(bus.req & ~gnt_q);
    // >= rather than == so a saturated counter still preempts once a rival shows up.
    assign limit_hit = (MAX_HOLD != 0) && (cnt >= LIMIT);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        pre_nxt   = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                gnt_nxt = 4'b0000;
                id_nxt  = 2'd0;
                if (win_hit) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << win_id;
                    id_nxt    = win_id;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    id_nxt    = 2'd0;
                end else if (limit_hit && others) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    id_nxt    = 2'd0;
                    pre_nxt   = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= 4'b0000;
            id_q  <= 2'd0;
            vld_q <= 1'b0;
            pre_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
            id_q  <= id_nxt;
            vld_q <= |gnt_nxt;
            pre_q <= pre_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = vld_q;
    assign bus.preempt   = pre_q;
endmodule

// File: doc/prio_arbiter4.md
# prio_arbiter4

Sequential 4-requester arbiter that shares one resource among four clients. Each cycle it resolves competing requests with the same 4-to-2 priority encoding the combinational encoders use: the highest index wins, and an encoded ID plus a valid flag are produced. It adds registered grants, grant locking, a hold-time limit with forced release, and optional round-robin fairness. It sits between the requesting blocks and a shared datapath or bus mux, driving the mux select from `gnt_id`.

## Interface
- `MAX_HOLD`, default 8. Maximum consecutive grant cycles before a forced release when other requests are pending. 0 disables the limit. Legal range 0..255.
- `CNT_W`, default 8. Width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1. Rising-edge clock.
- `rst` input 1. Asynchronous, active-high reset.
- `req` input 4. Request lines. `req[3]` has the highest fixed priority.
- `gnt` output 4. One-hot grant, registered.
- `gnt_id` output 2. Encoded index of the granted requester, registered.
- `gnt_valid` output 1. High while any grant is held. Always equals `|gnt`.
- `preempt` output 1. One-cycle pulse marking a forced release.

## Operation
- Reset values: `gnt`=0000, `gnt_id`=00, `gnt_valid`=0, `preempt`=0, hold counter=0, state=IDLE, round-robin low-priority pointer=0.
- Reset asserted mid-grant forces all of the above immediately (asynchronous); no grant survives reset.
- State IDLE:
  - All grant outputs are 0.
  - If `req`≠0 at a clock edge, move to GRANT. The winner is chosen by priority order (see Configuration).
  - Load `gnt` (one-hot), `gnt_id` and `gnt_valid`=1. Clear the hold counter to 0.
  - If `req`=0, stay in IDLE.
- State GRANT:
  - Outputs hold. The hold counter increments each cycle and saturates at 2^CNT_W−1.
  - Normal release: `req[gnt_id]`=0 at an edge → go to IDLE and clear all grant outputs.
  - Forced release: `MAX_HOLD`≠0, counter = MAX_HOLD−1, `req[gnt_id]` still 1, and any other `req` bit set → go to IDLE, clear the grant, and pulse `preempt`=1 for exactly that one cycle.
  - If the limit is reached with no other requester pending, keep the grant. The counter saturates and forced release happens at the first edge where another request appears.
  - If normal and forced release conditions are both true on the same edge, treat it as a normal release; `preempt` stays 0.
- Changes to non-granted `req` bits during GRANT have no effect on outputs.
- `gnt` is never multi-hot; `gnt_id` always encodes the single set bit.

## Timing
- Grant latency: a request sampled at edge k in IDLE gives `gnt` valid after edge k (1 cycle).
- Release latency: `req[gnt_id]` low sampled at edge m clears `gnt` after edge m.
- The state after a release is always IDLE, so there is a guaranteed one-cycle dead gap with `gnt_valid`=0 between consecutive grants. The earliest next grant is after edge m+1. Downstream mux switching relies on this gap.
- With `req` held continuously, a granted requester owns the resource for exactly MAX_HOLD cycles before a forced release (when others are pending).
- No combinational path from `req` to any output.

## Configuration
- `PRIO_ARB_ROUND_ROBIN_EN`:
  - Undefined: fixed priority 3 > 2 > 1 > 0, identical to the 4-to-2 priority encoder.
  - Defined: rotating priority. A 2-bit pointer `lo` marks the lowest-priority index. Search order is lo−1, lo−2, lo−3, lo (mod 4). On every grant to index i, `lo` ← i. Reset `lo`=0, so the first arbitration matches fixed order.
- MAX_HOLD and preemption behave the same in both modes.

## Test plan
- Reset and idle: `rst`=1 mid-grant with `req`=1111 → all outputs 0 immediately. Release `rst` with `req`=0000 → outputs stay 0.
- Fixed priority: from IDLE, `req`=0101 → after 1 edge `gnt`=0100, `gnt_id`=10, `gnt_valid`=1. Drop `req[2]` → `gnt`=0000 next edge, then `gnt`=0001 one edge later.
- Grant lock: grant held on id 1, then raise `req[3]` → `gnt` stays 0010 until `req[1]` drops; the next grant goes to id 3 after the dead cycle.
- Forced release with MAX_HOLD=4, `req`=1001 held → `gnt`=1000 for exactly 4 cycles, `preempt`=1 for one cycle, `gnt`=0 for one cycle. With the macro undefined the grant returns to 1000; with it defined the grant goes to 0001.
- No contention: MAX_HOLD=4, `req`=0010 held for 20 cycles → `gnt`=0010 throughout, `preempt` never asserts.
- Round robin (macro defined): `req`=1111 held with MAX_HOLD=2 → grant sequence is ids 3,2,1,0,3. Each grant lasts 2 cycles, separated by one-cycle gaps.
